// File: rtl/spi_fsm.sv
// Transaction controller for the SPI memory slave: sequences address capture, memory write
// and read-data load/shift-out from conditioned CS/SCLK edge pulses.
module spi_fsm #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_cond,
    input  logic                  sclk_pos,
    input  logic                  sclk_neg,
    input  logic [DATA_WIDTH-1:0] shift_data,
    output logic                  addr_we,
    output logic                  dm_we,
    output logic                  sr_we,
    output logic                  miso_buff,
    output logic [2:0]            state
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StGetAddr  = 3'd1,
        StGotAddr  = 3'd2,
        StReadLoad = 3'd3,
        StReadOut  = 3'd4,
        StWriteIn  = 3'd5,
        StWriteMem = 3'd6,
        StDone     = 3'd7
    } state_e;

    state_e          stateQ, stateD;
    logic [CntW-1:0] cntQ, cntD;

    // Only the rw bit is consumed here; the address bits go straight to the external latch.
    logic unusedAddrBits;
    assign unusedAddrBits = ^shift_data[ADDR_WIDTH:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        case (stateQ)
            StIdle: begin
                if (!cs_cond) stateD = StGetAddr;
            end
            StGetAddr: begin
                if (sclk_pos) begin
                    if (cntQ == LastCnt) stateD = StGotAddr;
                    else                 cntD   = cntQ + CntW'(1);
                end
            end
            StGotAddr:  stateD = shift_data[0] ? StReadLoad : StWriteIn;
            StReadLoad: stateD = StReadOut;
            StReadOut: begin
                if (sclk_neg) begin
                    if (cntQ == LastCnt) stateD = StDone;
                    else                 cntD   = cntQ + CntW'(1);
                end
            end
            StWriteIn: begin
                if (sclk_pos) begin
                    if (cntQ == LastCnt) stateD = StWriteMem;
                    else                 cntD   = cntQ + CntW'(1);
                end
            end
            StWriteMem: stateD = StDone;
            StDone:     stateD = StDone;
            default:    stateD = StIdle;
        endcase
        // Chip-select release aborts from anywhere and beats any edge pulse.
        if (stateQ != StIdle && cs_cond) stateD = StIdle;
        if (stateD != stateQ) cntD = '0;
    end

    always_comb begin
        addr_we   = 1'b0;
        dm_we     = 1'b0;
        sr_we     = 1'b0;
        miso_buff = 1'b0;
        case (stateQ)
            StGotAddr:  addr_we   = 1'b1;
            StReadLoad: sr_we     = 1'b1;
            StReadOut:  miso_buff = 1'b1;
            StWriteMem: dm_we     = 1'b1;
            default:    ;
        endcase
    end

    assign state = stateQ;

endmodule

// File: tb/tb_spi_fsm.sv
// Bench for spi_fsm: an edge-counting transaction model checked every cycle, plus directed
// write/read/abort/reset scenarios with literal expectations.
module tb_spi_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cs_cond = 1'b1;
    logic       sclk_pos = 1'b0;
    logic       sclk_neg = 1'b0;
    logic [7:0] shift_data = 8'h00;
    logic       addr_we, dm_we, sr_we, miso_buff;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    spi_fsm #(.DATA_WIDTH(8), .ADDR_WIDTH(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_cond   (cs_cond),
        .sclk_pos  (sclk_pos),
        .sclk_neg  (sclk_neg),
        .shift_data(shift_data),
        .addr_we   (addr_we),
        .dm_we     (dm_we),
        .sr_we     (sr_we),
        .miso_buff (miso_buff),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Transaction model: tracks edges counted in each phase and cycles since a phase completed.
    int mBusy = 0;
    int aCnt  = 0;
    int gapA  = -1;
    int dCnt  = 0;
    int gapD  = -1;
    bit mRw   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy <= 0; aCnt <= 0; gapA <= -1; dCnt <= 0; gapD <= -1;
        end else if (mBusy == 0) begin
            if (!cs_cond) begin
                mBusy <= 1; aCnt <= 0; gapA <= -1; dCnt <= 0; gapD <= -1;
            end
        end else if (cs_cond) begin
            mBusy <= 0;
        end else if (aCnt < 8) begin
            if (sclk_pos) begin
                aCnt <= aCnt + 1;
                if (aCnt == 7) gapA <= 0;
            end
        end else if (gapA == 0) begin
            mRw  <= shift_data[0];
            gapA <= 1;
        end else if (mRw && gapA == 1) begin
            gapA <= 2;
        end else if (dCnt < 8) begin
            if (mRw ? sclk_neg : sclk_pos) begin
                dCnt <= dCnt + 1;
                if (dCnt == 7) gapD <= 0;
            end
        end else if (gapD == 0) begin
            gapD <= 1;
        end
    end

    function automatic int expState();
        if (mBusy == 0) return 0;
        if (aCnt < 8)   return 1;
        if (gapA == 0)  return 2;
        if (mRw) begin
            if (gapA == 1) return 3;
            if (dCnt < 8)  return 4;
            return 7;
        end
        if (dCnt < 8)  return 5;
        if (gapD == 0) return 6;
        return 7;
    endfunction

    int cyc = 0;
    int addrWeCnt = 0, dmWeCnt = 0, srWeCnt = 0;
    int lastAddrCyc = 0, lastSrCyc = 0;

    always @(posedge clk) begin
        int es;
        logic [6:0] expV, actV;
        #1;
        cyc++;
        es   = expState();
        expV = {3'(es), es == 2, es == 6, es == 3, es == 4};
        actV = {state, addr_we, dm_we, sr_we, miso_buff};
        checks++;
        if (actV !== expV) begin
            errors++;
            $display("FAIL model cycle %0d: {state,addr_we,dm_we,sr_we,miso_buff} got %b want %b",
                     cyc, actV, expV);
        end
        if (addr_we) begin addrWeCnt++; lastAddrCyc = cyc; end
        if (dm_we)   dmWeCnt++;
        if (sr_we)   begin srWeCnt++; lastSrCyc = cyc; end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // One SCLK period (6 clk): rising pulse, shift in bit, then falling pulse.
    task automatic sclkBit(input logic b);
        @(negedge clk); sclk_pos = 1'b1;
        @(negedge clk); sclk_pos = 1'b0; shift_data = {shift_data[6:0], b};
        @(negedge clk);
        @(negedge clk); sclk_neg = 1'b1;
        @(negedge clk); sclk_neg = 1'b0;
        @(negedge clk);
    endtask

    // Both pulses in the same cycle.
    task automatic sclkBoth(input logic b);
        @(negedge clk); sclk_pos = 1'b1; sclk_neg = 1'b1;
        @(negedge clk); sclk_pos = 1'b0; sclk_neg = 1'b0; shift_data = {shift_data[6:0], b};
        repeat (4) @(negedge clk);
    endtask

    task automatic sendBits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) sclkBit(v[i]);
    endtask

    task automatic csLow();
        @(negedge clk); cs_cond = 1'b0;
        @(negedge clk);
    endtask

    task automatic csHigh(input int gap);
        @(negedge clk); cs_cond = 1'b1;
        repeat (gap) @(negedge clk);
        chk("cs_high_idle", int'(state), 0);
    endtask

    task automatic doWrite(input logic [7:0] frame, input logic [7:0] data);
        int a0, d0;
        a0 = addrWeCnt; d0 = dmWeCnt;
        csLow();
        chk("wr_get_addr", int'(state), 1);
        sendBits(frame, 8);
        chk("wr_state_write_in", int'(state), 5);
        chk("wr_addr_we_once", addrWeCnt - a0, 1);
        sendBits(data, 8);
        chk("wr_state_done", int'(state), 7);
        chk("wr_dm_we_once", dmWeCnt - d0, 1);
    endtask

    task automatic doRead(input logic [7:0] frame, input logic lastBoth);
        int a0, s0;
        a0 = addrWeCnt; s0 = srWeCnt;
        csLow();
        sendBits(frame, 8);
        chk("rd_state_read_out", int'(state), 4);
        chk("rd_miso_on", int'(miso_buff), 1);
        chk("rd_addr_we_once", addrWeCnt - a0, 1);
        chk("rd_sr_we_once", srWeCnt - s0, 1);
        chk("rd_sr_after_addr", lastSrCyc - lastAddrCyc, 1);
        sendBits(8'h00, 6);
        chk("rd_miso_after_7neg", int'(miso_buff), 1);
        if (lastBoth) sclkBoth(1'b0);
        else          sclkBit(1'b0);
        chk("rd_state_done", int'(state), 7);
        chk("rd_miso_off", int'(miso_buff), 0);
    endtask

    initial begin
        int a0, d0, s0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_outs", int'({addr_we, dm_we, sr_we, miso_buff}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_hold", int'(state), 0);

        // Write to 0x2A, then edges in DONE must not strobe.
        doWrite(8'h54, 8'hA5);
        a0 = addrWeCnt; d0 = dmWeCnt; s0 = srWeCnt;
        sendBits(8'hFF, 3);
        chk("done_state", int'(state), 7);
        chk("done_no_strobe", (addrWeCnt - a0) + (dmWeCnt - d0) + (srWeCnt - s0), 0);
        csHigh(2);

        // Read from 0x2A; rising pulses in READ_OUT are ignored.
        doRead(8'h55, 1'b0);
        csHigh(2);

        // Last falling edge arrives together with a rising edge.
        doRead(8'h55, 1'b1);
        csHigh(2);

        // Abort after 4 address edges; the next frame needs all 8 edges.
        a0 = addrWeCnt;
        csLow();
        sendBits(8'h54, 4);
        chk("abort_mid_addr", int'(state), 1);
        @(negedge clk); cs_cond = 1'b1;
        @(negedge clk);
        chk("abort_idle", int'(state), 0);
        chk("abort_no_addr_we", addrWeCnt - a0, 0);
        @(negedge clk);
        csLow();
        sendBits(8'h54, 7);
        chk("restart_7_edges", int'(state), 1);
        chk("restart_no_addr_we", addrWeCnt - a0, 0);
        sclkBit(1'b0);
        chk("restart_write_in", int'(state), 5);
        chk("restart_addr_we", addrWeCnt - a0, 1);
        csHigh(2);

        // Asynchronous reset in READ_OUT.
        csLow();
        sendBits(8'h55, 8);
        sendBits(8'h00, 2);
        chk("pre_reset_read_out", int'(state), 4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_state", int'(state), 0);
        chk("async_reset_miso", int'(miso_buff), 0);
        cs_cond = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", int'(state), 0);
        chk("post_reset_outs", int'({addr_we, dm_we, sr_we, miso_buff}), 0);

        // Back-to-back write then read with a 2-clk gap.
        doWrite(8'h54, 8'h3C);
        csHigh(2);
        doRead(8'h55, 1'b0);
        csHigh(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
